// File: rtl/uart_rx_vote_sampler_pkg.sv
// Shared definitions for the UART receive path: n_samples encoding, its decode,
// and oversampling limits.
package uart_rx_vote_sampler_pkg;

  localparam int EDGE_W_DEFAULT = 6;
  localparam int MIN_PRESCALE   = 4;

  typedef enum logic [1:0] {
    NS_1 = 2'b00,
    NS_3 = 2'b01,
    NS_5 = 2'b10,
    NS_7 = 2'b11
  } n_samples_e;

  function automatic logic [2:0] decode_n_samples(input logic [1:0] code);
    logic [2:0] n;
    n = 3'd1;
    case (code)
      NS_1: n = 3'd1;
      NS_3: n = 3'd3;
      NS_5: n = 3'd5;
      NS_7: n = 3'd7;
      default: n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_rx_vote_sampler_vote_window.sv
// Combinational vote-window calculator: sample span lo..hi centred on the bit
// midpoint, the decision point just after it, and whether the window fits.
module uart_vote_window
  import uart_rx_vote_sampler_pkg::*;
#(
  parameter int EDGE_W = EDGE_W_DEFAULT,
  parameter int VOTE_W = 3
) (
  input  logic [EDGE_W-1:0] prescale,
  input  logic [VOTE_W-1:0] n,
  output logic [EDGE_W-1:0] lo,
  output logic [EDGE_W-1:0] hi,
  output logic [EDGE_W-1:0] d,
  output logic              cfg_bad
);

  localparam logic [EDGE_W:0] ONE_W = (EDGE_W+1)'(1);

  // One extra bit of headroom so c+h+1 cannot wrap before the fit check.
  logic [EDGE_W:0] c_w;
  logic [EDGE_W:0] h_w;
  logic [EDGE_W:0] hi_w;
  logic [EDGE_W:0] d_w;

  always_comb begin
    c_w     = {1'b0, prescale} >> 1;
    h_w     = (EDGE_W+1)'((n - VOTE_W'(1)) >> 1);
    hi_w    = c_w + h_w;
    d_w     = hi_w + ONE_W;
    lo      = (c_w >= h_w) ? EDGE_W'(c_w - h_w) : '0;
    hi      = hi_w[EDGE_W-1:0];
    d       = d_w[EDGE_W-1:0];
    cfg_bad = (prescale < EDGE_W'(MIN_PRESCALE)) ||
              (c_w < h_w) ||
              (d_w >= {1'b0, prescale});
  end

endmodule

// File: rtl/uart_rx_vote_sampler.sv
// Majority-vote bit sampler for the UART receiver: counts ones over a window
// centred on the bit midpoint and emits the voted bit one cycle after the last sample.
module uart_rx_vote_sampler
  import uart_rx_vote_sampler_pkg::*;
#(
  parameter int EDGE_W      = EDGE_W_DEFAULT,
  parameter int MAX_SAMPLES = 7,
  parameter int VOTE_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              data,
  input  logic [EDGE_W-1:0] edge_cnt,
  input  logic [EDGE_W-1:0] prescale,
  input  logic [1:0]        n_samples,
  output logic              sampled_bit,
  output logic              sample_valid,
  output logic              noise_err,
  output logic              cfg_err
);

  logic [EDGE_W-1:0] prescale_reg;
  logic [VOTE_W-1:0] n_reg;
  logic [VOTE_W-1:0] ones_reg;
  logic [VOTE_W-1:0] taken_reg;
  logic              armed_reg;
  logic              sampled_bit_reg;
  logic              sample_valid_reg;
  logic              noise_err_reg;
  logic              cfg_err_reg;

  logic [VOTE_W-1:0] n_decoded;
  logic [VOTE_W-1:0] n_clamped;
  logic              latch_cfg;
  logic [EDGE_W-1:0] prescale_next;
  logic [VOTE_W-1:0] n_next;
  logic [EDGE_W-1:0] win_lo;
  logic [EDGE_W-1:0] win_hi;
  logic [EDGE_W-1:0] win_d;
  logic              win_cfg_bad;
  logic              active;
  logic              in_window;
  logic              at_decision;

  always_comb begin
    n_decoded = VOTE_W'(decode_n_samples(n_samples));
    n_clamped = (n_decoded > VOTE_W'(MAX_SAMPLES)) ? VOTE_W'(MAX_SAMPLES) : n_decoded;
    latch_cfg = en && (edge_cnt == '0);
  end

  // The calculator sees the incoming config on a latch cycle so cfg_err is
  // judged on the values being latched; on every other cycle it sees the latched ones.
  assign prescale_next = latch_cfg ? prescale  : prescale_reg;
  assign n_next        = latch_cfg ? n_clamped : n_reg;

  uart_vote_window #(
    .EDGE_W (EDGE_W),
    .VOTE_W (VOTE_W)
  ) u_window (
    .prescale (prescale_next),
    .n        (n_next),
    .lo       (win_lo),
    .hi       (win_hi),
    .d        (win_d),
    .cfg_bad  (win_cfg_bad)
  );

  // A usable window never includes edge 0, so the latch cycle never samples or decides.
  always_comb begin
    active      = en && armed_reg && !cfg_err_reg && !latch_cfg;
    in_window   = active && (edge_cnt >= win_lo) && (edge_cnt <= win_hi);
    at_decision = active && (edge_cnt == win_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale_reg     <= '0;
      n_reg            <= VOTE_W'(1);
      ones_reg         <= '0;
      taken_reg        <= '0;
      armed_reg        <= 1'b0;
      sampled_bit_reg  <= 1'b0;
      sample_valid_reg <= 1'b0;
      noise_err_reg    <= 1'b0;
      cfg_err_reg      <= 1'b0;
    end else begin
      sample_valid_reg <= 1'b0;
      if (!en) begin
        ones_reg  <= '0;
        taken_reg <= '0;
      end else if (latch_cfg) begin
        // Bit boundary: take the new config and drop any partial window.
        prescale_reg <= prescale;
        n_reg        <= n_clamped;
        cfg_err_reg  <= win_cfg_bad;
        armed_reg    <= 1'b1;
        ones_reg     <= '0;
        taken_reg    <= '0;
      end else if (at_decision) begin
        sampled_bit_reg  <= (ones_reg > (n_reg >> 1));
        noise_err_reg    <= (ones_reg != '0) && (ones_reg != n_reg);
        sample_valid_reg <= 1'b1;
        ones_reg         <= '0;
        taken_reg        <= '0;
      end else if (in_window) begin
        ones_reg  <= ones_reg + VOTE_W'(data);
        taken_reg <= taken_reg + VOTE_W'(1);
      end
    end
  end

  assign sampled_bit  = sampled_bit_reg;
  assign sample_valid = sample_valid_reg;
  assign noise_err    = noise_err_reg;
  assign cfg_err      = cfg_err_reg;

endmodule

// File: tb/tb_uart_rx_vote_sampler.sv
// Self-checking bench for uart_rx_vote_sampler: directed scenarios plus random
// bits, checked against a queue-based majority-vote model.
module tb_uart_rx_vote_sampler;

  localparam int MAX_SAMPLES = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       data = 1'b0;
  logic [5:0] edge_cnt = '0;
  logic [5:0] prescale = '0;
  logic [1:0] n_samples = '0;
  logic       sampled_bit;
  logic       sample_valid;
  logic       noise_err;
  logic       cfg_err;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  int m_p, m_n;
  bit m_cfg, m_armed;
  bit exp_bit, exp_noise, exp_valid;
  bit samples[$];

  uart_rx_vote_sampler #(
    .EDGE_W      (6),
    .MAX_SAMPLES (MAX_SAMPLES),
    .VOTE_W      (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .data         (data),
    .edge_cnt     (edge_cnt),
    .prescale     (prescale),
    .n_samples    (n_samples),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid),
    .noise_err    (noise_err),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    m_p = 0; m_n = 1; m_cfg = 0; m_armed = 0;
    exp_bit = 0; exp_noise = 0; exp_valid = 0;
    samples.delete();
  endtask

  // Drive one oversample cycle, advance the model on the clock edge, settle 1 time unit.
  task automatic step(input bit e, input bit d_in, input int ec, input int p, input int code);
    int c, h, ones;
    en = e; data = d_in; edge_cnt = 6'(ec); prescale = 6'(p); n_samples = 2'(code);
    @(posedge clk);
    exp_valid = 0;
    if (!rst) model_reset();
    else if (!e) samples.delete();
    else if (ec == 0) begin
      m_p = p;
      m_n = 2 * code + 1;
      if (m_n > MAX_SAMPLES) m_n = MAX_SAMPLES;
      c = m_p / 2; h = (m_n - 1) / 2;
      m_cfg = (m_p < 4) || (c < h) || (c + h + 1 > m_p - 1);
      m_armed = 1;
      samples.delete();
    end else if (m_armed && !m_cfg) begin
      c = m_p / 2; h = (m_n - 1) / 2;
      if (ec >= c - h && ec <= c + h) samples.push_back(d_in);
      else if (ec == c + h + 1) begin
        ones = 0;
        foreach (samples[i]) ones += int'(samples[i]);
        exp_bit   = (2 * ones > m_n);
        exp_noise = (ones != 0) && (ones != m_n);
        exp_valid = 1;
        samples.delete();
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 8, 1);
      vectors++;
      if ({sample_valid, sampled_bit, noise_err, cfg_err} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_state cyc=%0d got vbnc=%b%b%b%b want 0000", i,
                 sample_valid, sampled_bit, noise_err, cfg_err);
      end
    end
    rst = 1'b1;
    $display("reset released");
  endtask

  task automatic test_vote_basic();
    int pulses = 0, vedge = -1;
    for (int e = 0; e < 8; e++) begin
      step(1, 1, e, 8, 1);
      vectors++;
      if ({sample_valid, sampled_bit, noise_err, cfg_err} !== {exp_valid, exp_bit, exp_noise, m_cfg}) begin
        errors++;
        $display("FAIL basic_cycle edge=%0d got vbnc=%b%b%b%b want %b%b%b%b", e,
                 sample_valid, sampled_bit, noise_err, cfg_err, exp_valid, exp_bit, exp_noise, m_cfg);
      end
      if (sample_valid) begin pulses++; vedge = e; end
    end
    vectors++;
    if (pulses !== 1 || vedge !== 6 || sampled_bit !== 1'b1 || noise_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_decision got pulses=%0d at_edge=%0d bit=%b noise=%b want 1 6 1 0",
               pulses, vedge, sampled_bit, noise_err);
    end
    $display("basic: p=8 n=3 -> bit=%b noise=%b", sampled_bit, noise_err);
  endtask

  task automatic test_noise();
    bit pat[5] = '{0, 1, 0, 1, 1};
    for (int b = 0; b < 2; b++) begin
      for (int e = 0; e < 16; e++) begin
        step(1, (b == 0 && e >= 6 && e <= 10) ? pat[e-6] : 1'b0, e, 16, 2);
        vectors++;
        if ({sample_valid, sampled_bit, noise_err, cfg_err} !== {exp_valid, exp_bit, exp_noise, m_cfg}) begin
          errors++;
          $display("FAIL noise_cycle bit=%0d edge=%0d got vbnc=%b%b%b%b want %b%b%b%b", b, e,
                   sample_valid, sampled_bit, noise_err, cfg_err, exp_valid, exp_bit, exp_noise, m_cfg);
        end
      end
      vectors++;
      if ({sampled_bit, noise_err} !== ((b == 0) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL noise_result bit=%0d got bit/noise=%b%b want %s", b, sampled_bit, noise_err,
                 (b == 0) ? "11" : "00");
      end
      $display("noise: bit %0d -> bit=%b noise=%b", b, sampled_bit, noise_err);
    end
  endtask

  task automatic test_cfg_err();
    int pulses = 0, vedge = -1;
    for (int e = 0; e < 4; e++) begin
      step(1, 1, e, 4, 3);
      vectors++;
      if ({sample_valid, sampled_bit, noise_err, cfg_err} !== {exp_valid, exp_bit, exp_noise, m_cfg}) begin
        errors++;
        $display("FAIL cfgerr_cycle edge=%0d got vbnc=%b%b%b%b want %b%b%b%b", e,
                 sample_valid, sampled_bit, noise_err, cfg_err, exp_valid, exp_bit, exp_noise, m_cfg);
      end
      if (sample_valid) pulses++;
      if (e == 0) begin
        vectors++;
        if (cfg_err !== 1'b1) begin
          errors++;
          $display("FAIL cfgerr_set got cfg_err=%b want 1", cfg_err);
        end
      end
    end
    vectors++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL cfgerr_no_valid got pulses=%0d want 0", pulses);
    end
    for (int e = 0; e < 4; e++) begin
      step(1, (e == 2) ? 1'b0 : 1'b1, e, 4, 0);
      vectors++;
      if ({sample_valid, sampled_bit, noise_err, cfg_err} !== {exp_valid, exp_bit, exp_noise, m_cfg}) begin
        errors++;
        $display("FAIL cfgok_cycle edge=%0d got vbnc=%b%b%b%b want %b%b%b%b", e,
                 sample_valid, sampled_bit, noise_err, cfg_err, exp_valid, exp_bit, exp_noise, m_cfg);
      end
      if (sample_valid) vedge = e;
    end
    vectors++;
    if (cfg_err !== 1'b0 || vedge !== 3 || sampled_bit !== 1'b0) begin
      errors++;
      $display("FAIL cfgok_decision got cfg_err=%b at_edge=%0d bit=%b want 0 3 0", cfg_err, vedge, sampled_bit);
    end
    $display("cfg: p=4 n=7 rejected, p=4 n=1 -> bit=%b", sampled_bit);
  endtask

  task automatic test_mid_change();
    bit d[16];
    int ones, vedge;
    for (int b = 0; b < 2; b++) begin
      vedge = -1;
      foreach (d[i]) d[i] = 1'($urandom_range(0, 1));
      for (int e = 0; e < 16; e++) begin
        step(1, d[e], e, 16, (b == 0 && e < 7) ? 1 : 3);
        vectors++;
        if ({sample_valid, sampled_bit, noise_err, cfg_err} !== {exp_valid, exp_bit, exp_noise, m_cfg}) begin
          errors++;
          $display("FAIL midchg_cycle bit=%0d edge=%0d got vbnc=%b%b%b%b want %b%b%b%b", b, e,
                   sample_valid, sampled_bit, noise_err, cfg_err, exp_valid, exp_bit, exp_noise, m_cfg);
        end
        if (sample_valid) vedge = e;
      end
      ones = 0;
      if (b == 0) for (int i = 7; i <= 9; i++) ones += int'(d[i]);
      else        for (int i = 5; i <= 11; i++) ones += int'(d[i]);
      vectors++;
      if (vedge !== ((b == 0) ? 10 : 12) || sampled_bit !== ((b == 0) ? (ones >= 2) : (ones >= 4))) begin
        errors++;
        $display("FAIL midchg_decision bit=%0d got at_edge=%0d bit=%b want edge %0d, ones=%0d",
                 b, vedge, sampled_bit, (b == 0) ? 10 : 12, ones);
      end
      $display("midchg: bit %0d ones=%0d -> bit=%b noise=%b", b, ones, sampled_bit, noise_err);
    end
  endtask

  task automatic test_en_drop();
    bit pat[5] = '{0, 0, 1, 0, 0};
    int pulses = 0;
    for (int e = 0; e < 16; e++) begin
      step(e < 9, 1, e, 16, 2);
      vectors++;
      if ({sample_valid, sampled_bit, noise_err, cfg_err} !== {exp_valid, exp_bit, exp_noise, m_cfg}) begin
        errors++;
        $display("FAIL endrop_cycle edge=%0d got vbnc=%b%b%b%b want %b%b%b%b", e,
                 sample_valid, sampled_bit, noise_err, cfg_err, exp_valid, exp_bit, exp_noise, m_cfg);
      end
      if (sample_valid) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL endrop_no_valid got pulses=%0d want 0", pulses);
    end
    for (int e = 0; e < 16; e++) begin
      step(1, (e >= 6 && e <= 10) ? pat[e-6] : 1'b1, e, 16, 2);
      vectors++;
      if ({sample_valid, sampled_bit, noise_err, cfg_err} !== {exp_valid, exp_bit, exp_noise, m_cfg}) begin
        errors++;
        $display("FAIL endrop_next_cycle edge=%0d got vbnc=%b%b%b%b want %b%b%b%b", e,
                 sample_valid, sampled_bit, noise_err, cfg_err, exp_valid, exp_bit, exp_noise, m_cfg);
      end
    end
    vectors++;
    if ({sampled_bit, noise_err} !== 2'b01) begin
      errors++;
      $display("FAIL endrop_fresh got bit/noise=%b%b want 01", sampled_bit, noise_err);
    end
    $display("endrop: next bit -> bit=%b noise=%b", sampled_bit, noise_err);
  endtask

  task automatic test_reset_mid();
    bit pat1[5] = '{1, 1, 1, 0, 0};
    bit pat3[5] = '{0, 0, 0, 1, 1};
    int pulses = 0, vedge = -1;
    for (int e = 0; e < 16; e++) step(1, (e >= 6 && e <= 10) ? pat1[e-6] : 1'b0, e, 16, 2);
    vectors++;
    if ({sampled_bit, noise_err} !== 2'b11) begin
      errors++;
      $display("FAIL rstmid_setup got bit/noise=%b%b want 11", sampled_bit, noise_err);
    end
    for (int e = 0; e < 8; e++) step(1, 1, e, 16, 2);
    rst = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({sample_valid, sampled_bit, noise_err, cfg_err} !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_async got vbnc=%b%b%b%b want 0000", sample_valid, sampled_bit, noise_err, cfg_err);
    end
    step(1, 1, 8, 16, 2);
    rst = 1'b1;
    for (int e = 9; e < 16; e++) begin
      step(1, 1, e, 16, 2);
      vectors++;
      if ({sample_valid, sampled_bit, noise_err, cfg_err} !== {exp_valid, exp_bit, exp_noise, m_cfg}) begin
        errors++;
        $display("FAIL rstmid_tail edge=%0d got vbnc=%b%b%b%b want %b%b%b%b", e,
                 sample_valid, sampled_bit, noise_err, cfg_err, exp_valid, exp_bit, exp_noise, m_cfg);
      end
      if (sample_valid) pulses++;
    end
    for (int e = 0; e < 16; e++) begin
      step(1, (e >= 6 && e <= 10) ? pat3[e-6] : 1'b1, e, 16, 2);
      vectors++;
      if ({sample_valid, sampled_bit, noise_err, cfg_err} !== {exp_valid, exp_bit, exp_noise, m_cfg}) begin
        errors++;
        $display("FAIL rstmid_next edge=%0d got vbnc=%b%b%b%b want %b%b%b%b", e,
                 sample_valid, sampled_bit, noise_err, cfg_err, exp_valid, exp_bit, exp_noise, m_cfg);
      end
      if (sample_valid) begin pulses++; vedge = e; end
    end
    vectors++;
    if (pulses !== 1 || vedge !== 11 || {sampled_bit, noise_err} !== 2'b01) begin
      errors++;
      $display("FAIL rstmid_decision got pulses=%0d at_edge=%0d bit/noise=%b%b want 1 11 01",
               pulses, vedge, sampled_bit, noise_err);
    end
    $display("rstmid: first post-reset bit -> bit=%b noise=%b", sampled_bit, noise_err);
  endtask

  task automatic test_random();
    int p, code, drop_at, chg_at, code2, pulses;
    bit prev_valid;
    for (int b = 0; b < 40; b++) begin
      p       = int'($urandom_range(2, 63));
      code    = int'($urandom_range(0, 3));
      code2   = int'($urandom_range(0, 3));
      drop_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, p - 1)) : p;
      chg_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, p - 1)) : p;
      pulses  = 0;
      prev_valid = 1'b0;
      for (int e = 0; e < p; e++) begin
        step(e < drop_at, 1'($urandom_range(0, 1)), e, p, (e < chg_at) ? code : code2);
        vectors++;
        if ({sample_valid, sampled_bit, noise_err, cfg_err} !== {exp_valid, exp_bit, exp_noise, m_cfg} ||
            (prev_valid && sample_valid)) begin
          errors++;
          $display("FAIL random_cycle bit=%0d p=%0d edge=%0d got vbnc=%b%b%b%b want %b%b%b%b",
                   b, p, e, sample_valid, sampled_bit, noise_err, cfg_err, exp_valid, exp_bit, exp_noise, m_cfg);
        end
        prev_valid = sample_valid;
        if (sample_valid) pulses++;
      end
      $display("random bit %0d: p=%0d code=%0d drop=%0d -> valids=%0d bit=%b noise=%b cfg=%b",
               b, p, code, drop_at, pulses, sampled_bit, noise_err, cfg_err);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_vote_basic();
    test_noise();
    test_cfg_err();
    test_mid_change();
    test_en_drop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
